// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: skid-register state encoding, count width and
// the default NOP payload used as the bubble value.
package pipe_skid_reg_pkg;

   localparam int unsigned MAX_DATA_W = 256;
   localparam int unsigned CNT_W      = 2;

   // Encoding equals the number of held entries, so count is the state itself
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   // NOP payload; instances slice it down to their own width
   localparam logic [MAX_DATA_W-1:0] NOP_PAYLOAD = '0;

endpackage : pipe_skid_reg_pkg

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with optional skid entry.
//
// Macro PIPE_SKID_BUF_EN: when defined, the stage holds up to two entries and
// in_ready depends only on registered state and hold. When undefined, the stage
// holds a single entry and in_ready also looks at out_ready.
//
// Ports
//   cpu_clk_50M  in   clock, all state on rising edge
//   cpu_rst_n    in   asynchronous active-low reset
//   in_valid     in   upstream offers in_data
//   in_ready     out  stage accepts in_data this cycle
//   in_data      in   upstream payload [DATA_W]
//   out_valid    out  out_data holds a valid entry
//   out_ready    in   downstream consumes out_data this cycle
//   out_data     out  head entry, BUBBLE_VAL when out_valid=0 [DATA_W]
//   flush        in   discard all entries, highest priority
//   hold         in   global freeze, no accept or release
//   count        out  number of held entries (0..2)
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int unsigned            DATA_W     = 64,
   parameter logic [DATA_W-1:0]      BUBBLE_VAL = NOP_PAYLOAD[DATA_W-1:0]
) (
   input  logic              cpu_clk_50M,
   input  logic              cpu_rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   input  logic              hold,
   output logic [CNT_W-1:0]  count
);

   skid_state_e       state_q, state_d;
   logic [DATA_W-1:0] head_q,  head_d;
`ifdef PIPE_SKID_BUF_EN
   logic [DATA_W-1:0] skid_q,  skid_d;
`endif

   logic accept_c;
   logic release_c;

   // Handshake outputs; hold forces both low so a frozen stage cannot move
`ifdef PIPE_SKID_BUF_EN
   assign in_ready  = (state_q != ST_TWO) & ~hold;
`else
   assign in_ready  = ((state_q == ST_EMPTY) | out_ready) & ~hold;
`endif
   assign out_valid = (state_q != ST_EMPTY) & ~hold;
   assign out_data  = out_valid ? head_q : BUBBLE_VAL;
   assign count     = CNT_W'(state_q);

   assign accept_c  = in_valid & in_ready;
   assign release_c = out_valid & out_ready;

   // Next-state and entry update; payload is only captured on an accept
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
`ifdef PIPE_SKID_BUF_EN
      skid_d  = skid_q;
`endif
      if (flush) begin
         state_d = ST_EMPTY;
         head_d  = BUBBLE_VAL;
`ifdef PIPE_SKID_BUF_EN
         skid_d  = BUBBLE_VAL;
`endif
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (accept_c) begin
                  head_d  = in_data;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept_c && release_c) begin
                  head_d = in_data;
`ifdef PIPE_SKID_BUF_EN
               end else if (accept_c) begin
                  // Head is blocked downstream; park the new entry behind it
                  skid_d  = in_data;
                  state_d = ST_TWO;
`endif
               end else if (release_c) begin
                  head_d  = BUBBLE_VAL;
                  state_d = ST_EMPTY;
               end
            end
`ifdef PIPE_SKID_BUF_EN
            ST_TWO: begin
               if (release_c) begin
                  head_d  = skid_q;
                  skid_d  = BUBBLE_VAL;
                  state_d = ST_ONE;
               end
            end
`endif
            default: begin
               state_d = ST_EMPTY;
               head_d  = BUBBLE_VAL;
            end
         endcase
      end
   end

   // State and entry registers
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_q <= ST_EMPTY;
         head_q  <= BUBBLE_VAL;
`ifdef PIPE_SKID_BUF_EN
         skid_q  <= BUBBLE_VAL;
`endif
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
`ifdef PIPE_SKID_BUF_EN
         skid_q  <= skid_d;
`endif
      end
   end

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_pipe_skid_reg;

`ifdef PIPE_SKID_BUF_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic        cpu_clk_50M;
   logic        cpu_rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        flush;
   logic        hold;
   logic [1:0]  count;

   pipe_skid_reg dut (
      .cpu_clk_50M (cpu_clk_50M),
      .cpu_rst_n   (cpu_rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .flush       (flush),
      .hold        (hold),
      .count       (count)
   );

   initial cpu_clk_50M = 1'b0;
   always #10 cpu_clk_50M = ~cpu_clk_50M;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Reference model: FIFO contents in acceptance order
   logic [63:0] mq[$];

   // Values sampled in the last cycle() call
   logic        s_ov, s_ir;
   logic [63:0] s_od;
   logic [1:0]  s_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
   endtask

   // Drive one cycle of inputs, compare outputs with the model, advance the model
   task automatic cycle(input logic f, input logic h, input logic iv, input logic orr,
                        input logic [63:0] d);
      logic        e_ov, e_ir;
      logic [63:0] e_od;
      @(negedge cpu_clk_50M);
      flush = f; hold = h; in_valid = iv; out_ready = orr; in_data = d;
      #1;
      s_ov = out_valid; s_ir = in_ready; s_od = out_data; s_cnt = count;
      e_ov = (mq.size() != 0) && !h;
      e_od = e_ov ? mq[0] : 64'h0;
      if (CAP == 2) e_ir = (mq.size() != 2) && !h;
      else          e_ir = ((mq.size() == 0) || orr) && !h;
      chk("model.out_valid", 64'(s_ov), 64'(e_ov));
      chk("model.out_data",  s_od, e_od);
      chk("model.in_ready",  64'(s_ir), 64'(e_ir));
      chk("model.count",     64'(s_cnt), 64'(mq.size()));
      if (f) mq.delete();
      else begin
         if (e_ov && orr) void'(mq.pop_front());
         if (iv && e_ir)  mq.push_back(d);
      end
      @(posedge cpu_clk_50M);
      cyc++;
   endtask

   typedef struct {
      logic        f, h, iv, orr;
      logic [63:0] d;
      logic        ev;
      logic [63:0] ed;
      logic        er;
      logic [1:0]  ec;
   } vec_t;

   vec_t tbl[8];

   initial begin
      // Outputs expected before each edge; rows cover first transfer and hold
      tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h11, 1'b0, 64'h0,  1'b1, 2'd0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h0,  1'b1, 64'h11, 1'b1, 2'd1};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h33, 1'b0, 64'h0,  1'b1, 2'd0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h44, 1'b0, 64'h0,  1'b0, 2'd1};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h45, 1'b0, 64'h0,  1'b0, 2'd1};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h46, 1'b0, 64'h0,  1'b0, 2'd1};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h0,  1'b1, 64'h33, 1'b1, 2'd1};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 2'd0};

      cpu_rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; in_data = 64'h0;
      repeat (2) @(posedge cpu_clk_50M);
      #1;
      chk("reset.out_valid", 64'(out_valid), 64'h0);
      chk("reset.out_data",  out_data, 64'h0);
      chk("reset.count",     64'(count), 64'h0);
      @(negedge cpu_clk_50M);
      cpu_rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 8; i++) begin
         cycle(tbl[i].f, tbl[i].h, tbl[i].iv, tbl[i].orr, tbl[i].d);
         chk($sformatf("tbl%0d.out_valid", i), 64'(s_ov), 64'(tbl[i].ev));
         chk($sformatf("tbl%0d.out_data", i),  s_od, tbl[i].ed);
         chk($sformatf("tbl%0d.in_ready", i),  64'(s_ir), 64'(tbl[i].er));
         chk($sformatf("tbl%0d.count", i),     64'(s_cnt), 64'(tbl[i].ec));
      end

      // Back-pressure fill then in-order drain
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'hA1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'hA2);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
`ifdef PIPE_SKID_BUF_EN
      chk("fill.count", 64'(s_cnt), 64'd2);
      chk("fill.in_ready", 64'(s_ir), 64'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
      chk("drain0.data", s_od, 64'hA1);
      chk("drain0.count", 64'(s_cnt), 64'd2);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
      chk("drain1.data", s_od, 64'hA2);
      chk("drain1.count", 64'(s_cnt), 64'd1);
`else
      chk("fill.count", 64'(s_cnt), 64'd1);
      chk("fill.in_ready", 64'(s_ir), 64'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
      chk("drain0.data", s_od, 64'hA1);
`endif
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
      chk("drained.count", 64'(s_cnt), 64'd0);
      chk("drained.out_valid", 64'(s_ov), 64'd0);

      // Flush beats a simultaneous push
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'hB1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'hB2);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 64'hFF);
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
         chk("flush.count", 64'(s_cnt), 64'd0);
         chk("flush.out_valid", 64'(s_ov), 64'd0);
         chk("flush.out_data", s_od, 64'h0);
      end

      // Streaming 0..99 at one transfer per cycle
      for (int i = 0; i <= 100; i++) begin
         cycle(1'b0, 1'b0, i < 100, 1'b1, 64'(i));
         if (i > 0) begin
            chk("stream.data", s_od, 64'(i - 1));
            chk("stream.count", 64'(s_cnt), 64'd1);
         end
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);

      // Asynchronous reset mid-stream
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'hC1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'hC2);
      @(negedge cpu_clk_50M);
      out_ready = 1'b1; in_valid = 1'b0;
      #2 cpu_rst_n = 1'b0;
      #1;
      chk("async_rst.out_valid", 64'(out_valid), 64'h0);
      chk("async_rst.count",     64'(count), 64'h0);
      chk("async_rst.out_data",  out_data, 64'h0);
      mq.delete();
      @(negedge cpu_clk_50M);
      cpu_rst_n = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 64'h55);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
      chk("post_rst.data", s_od, 64'h55);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
               {$urandom(), $urandom()});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_pipe_skid_reg

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, payload width in bits (legal 1..256).
REQ-002 SHALL have parameter BUBBLE_VAL, default {DATA_W{1'b0}}, the payload driven whenever no valid entry is presented (NOP encoding).
REQ-003 SHALL have port cpu_clk_50M  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port cpu_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port out_valid  output  1  out_data is a valid entry.
REQ-009 SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 SHALL have port out_data  output  DATA_W  head entry, or BUBBLE_VAL when out_valid=0.
REQ-011 SHALL have port flush  input  1  discard all entries (exception/redirect).
REQ-012 SHALL have port hold  input  1  global freeze (memory-access stall).
REQ-013 SHALL have port count  output  2  entries held (0..2).

Function
REQ-014 SHALL accept an entry on a rising edge iff in_valid=1 and in_ready=1, and release one iff out_valid=1 and out_ready=1.
REQ-015 SHALL present entries in strict acceptance order; an entry accepted at edge N SHALL be on out_data with out_valid=1 after edge N (1-cycle latency, no combinational in_data->out_data path).
REQ-016 SHALL implement states EMPTY (count=0), ONE (count=1), TWO (count=2, skid entry occupied).
REQ-017 SHALL transition EMPTY->ONE on accept; ONE->EMPTY on release without accept; ONE->TWO on accept without release; ONE stays on simultaneous accept+release; TWO->ONE on release (no accept possible in TWO).
REQ-018 SHALL drive out_valid = (count!=0) & ~hold, and out_data = BUBBLE_VAL whenever out_valid=0.
REQ-019 SHALL drive in_ready = (count!=2) & ~hold, as a function of registered state and hold only (no out_ready path).
REQ-020 SHALL, when hold=1, perform no accept or release and keep all entries and count unchanged.
REQ-021 SHALL, when flush=1 at an edge, set count=0 and discard all entries and any simultaneous in_valid input; flush SHALL take priority over hold, accept and release.
REQ-022 SHALL ignore in_data and out_ready values when the corresponding handshake is not completed; no X propagation into stored entries.

Reset
REQ-023 SHALL, while cpu_rst_n=0, asynchronously force state EMPTY, count=0, out_valid=0, out_data=BUBBLE_VAL, stored entries=BUBBLE_VAL; in_ready SHALL be 1 once cpu_rst_n=1 and hold=0.
REQ-024 SHALL discard any in-flight entry on reset mid-operation; the first accept after deassertion begins a fresh sequence.

Configuration
REQ-025 SHALL, with macro PIPE_SKID_BUF_EN defined, implement the two-entry behaviour of REQ-016..REQ-019.
REQ-026 SHALL, without PIPE_SKID_BUF_EN, implement a single entry: state TWO unreachable, count max 1, in_ready = (count==0 | out_ready) & ~hold (combinational out_ready->in_ready path permitted); all other requirements unchanged.

Structure
REQ-027 SHALL take state encodings (EMPTY/ONE/TWO) and the default NOP payload constant from the shared pipeline package/defines file.
REQ-028 SHALL be a single module with no sub-modules; stage-specific payload packing is done by instantiating wrappers, not inside this block.

Verification
REQ-029 SHALL verify: reset, then in_valid=1 data 0x11 with out_ready=1 -> out_data=0x11, out_valid=1 one cycle later; count=1.
REQ-030 SHALL verify: out_ready=0, push 0xA1 then 0xA2 -> count=2, in_ready=0; then out_ready=1 -> 0xA1 then 0xA2 in order, count 2->1->0.
REQ-031 SHALL verify: count=2, flush=1 with in_valid=1 data 0xFF -> next cycle count=0, out_valid=0, out_data=BUBBLE_VAL, 0xFF never appears.
REQ-032 SHALL verify: count=1 holding 0x33, hold=1 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, count=1; hold=0 -> 0x33 emitted unchanged.
REQ-033 SHALL verify: continuous in_valid=out_ready=1 with 0..99 -> 100 transfers back-to-back, one per cycle, in order, count stays 1.
REQ-034 SHALL verify: cpu_rst_n pulsed low mid-stream with count=2 -> out_valid=0 immediately (asynchronous), count=0, old entries never emitted.
